jesd204b_link_tx_ctrl: RTL and testbench
========================================

Name: jesd204b_link_tx_ctrl

Overview:
Multi-lane TX data-link controller that performs JESD204B link establishment ahead of the 8B10B encoders. It sequences Code Group Synchronisation (CGS), the Initial Lane Alignment Sequence (ILAS) and user data for LANES lanes, one octet per lane per clock. It handles the SYNC~ handshake from the receiver and generates the local multiframe clock (LMFC). It sits between the scrambler outputs and the Enc8B10B instances, and drives each encoder's octet and K-control inputs.

Parameters:
LANES, 4, number of lanes (1..8)
F, 2, octets per frame
K, 16, frames per multiframe; F*K must be in 17..1024
ILAS_MF, 4, multiframes in ILAS (2..8)
SYNC_FILTER, 5, consecutive low sync_n samples needed to request resync (1..15)

Ports:
clock  in  1  link/octet clock
reset  in  1  asynchronous, active-low reset
sync_n  in  1  SYNC~ from receiver, asynchronous, active-low
tx_data  in  LANES*8  scrambled user octets; lane i in [i*8+:8]
cfg_data  in  14*8  ILAS link config octets 0..13; octet j in [j*8+:8]
tx_octet  out  LANES*8  octet to encoder per lane
tx_k  out  LANES  K-character flag per lane
tx_ready  out  1  high when tx_data is being transmitted
lmfc_edge  out  1  one-cycle pulse at LMFC octet count 0
link_state  out  2  0=CGS, 1=ILAS, 2=DATA

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State = CGS.
  - lmfc_cnt = 0.
  - tx_octet = 8'hBC on every lane, tx_k = all ones.
  - tx_ready = 0, lmfc_edge = 0, link_state = 0.
  - Synchroniser flops = 0.
- sync_n passes through a 2-flop synchroniser; sync_s is the second-stage output. The filter counter counts consecutive cycles with sync_s=0 and saturates at SYNC_FILTER; it clears when sync_s=1.
- LMFC:
  - lmfc_cnt free-runs 0..F*K-1 and wraps to 0.
  - lmfc_edge is registered and high in the same cycle the outputs carry octet index 0.
- All outputs are registered. tx_data to tx_octet latency is 1 clock.
- CGS:
  - Every lane sends K28.5 (8'hBC, k=1).
  - When sync_s=1, leave CGS only at the next LMFC boundary: the cycle with lmfc_cnt wrapping to 0 enters ILAS, with mf_cnt=0.
  - If sync_s returns to 0 before the boundary, remain in CGS.
- ILAS, per octet index n within multiframe m:
  - n=0: K28.0 (8'h1C, k=1).
  - n=F*K-1: K28.3 (8'h7C, k=1).
  - m=1, n=1: K28.4 (8'h9C, k=1).
  - m=1, n=2..15: config octet j=n-2, k=0.
    - j=2 (LID) is replaced by the lane index i.
    - j=13 (FCHK) is replaced by the 8-bit sum of octets j=0..12 after LID substitution, mod 256, computed per lane.
  - All other octets: n[7:0], k=0.
  - After the /A/ of multiframe ILAS_MF-1, go to DATA on the next cycle, which is LMFC octet 0.
- DATA:
  - tx_octet = tx_data registered, tx_k = 0, tx_ready = 1.
  - No alignment-character replacement; scrambled mode only.
- Resync:
  - In ILAS or DATA, when the filter counter reaches SYNC_FILTER, the next cycle is CGS.
  - tx_ready drops in that same cycle.
  - No LMFC alignment is required for entry to CGS.
- A sync_s low pulse shorter than SYNC_FILTER cycles is ignored.
- Simultaneous events:
  - Resync request takes priority over the ILAS→DATA transition.
  - At the CGS→ILAS boundary, sync_s must be 1 in the boundary cycle.
- Reset mid-ILAS or mid-DATA: outputs go to reset values immediately (asynchronously), and the LMFC restarts from 0.

Test Plan:
- Reset, then hold sync_n=0 for 100 cycles (LANES=4) → every cycle tx_octet=32'hBCBCBCBC, tx_k=4'hF, tx_ready=0, lmfc_edge every 32 cycles (F=2, K=16).
- Release sync_n at lmfc_cnt=10 → CGS continues until the wrap. The first ILAS octet is 8'h1C on all lanes, coincident with lmfc_edge. ILAS lasts 128 cycles, then link_state=2.
- cfg_data octets 0..13 = 8'h01..8'h0E → in MF1, lane 3 octet n=4 = 8'h03, octet n=15 = FCHK = 8'h01+8'h02+8'h03+8'h04+...+8'h0D, with 8'h03 substituted as lane 3's LID. n=1 = 8'h9C with k=1. n=31 = 8'h7C.
- In DATA, tx_data=32'hA5A55A5A → tx_octet=32'hA5A55A5A one cycle later, tx_k=0, tx_ready=1.
- In DATA, pulse sync_n low for 4 cycles → still DATA. Then hold it low for 5 cycles → CGS (8'hBC, tx_ready=0) on the following cycle, accounting for 2-cycle synchroniser delay.
- Assert reset (0) during ILAS multiframe 2 → immediate CGS outputs and lmfc_cnt=0. After release with sync_n=1, ILAS starts at the first LMFC boundary (cycle 32).

Source files
------------

// File: rtl/jesd204b_link_tx_ctrl.sv
// JESD204B TX link controller: CGS/ILAS/DATA sequencing, SYNC~ filtering and LMFC, octet per lane per clock.
// Latency: tx_data to tx_octet 1 clock, all outputs registered; no backpressure, the octet stream never stalls.
module jesd204b_link_tx_ctrl #(
   parameter int LANES       = 4,
   parameter int F           = 2,
   parameter int K           = 16,
   parameter int ILAS_MF     = 4,
   parameter int SYNC_FILTER = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 sync_n,
   input  logic [LANES*8-1:0]   tx_data,
   input  logic [14*8-1:0]      cfg_data,
   output logic [LANES*8-1:0]   tx_octet,
   output logic [LANES-1:0]     tx_k,
   output logic                 tx_ready,
   output logic                 lmfc_edge,
   output logic [1:0]           link_state
);

   localparam int                FK       = F * K;
   localparam int                CNT_W    = $clog2(FK);
   localparam logic [CNT_W-1:0]  LMFC_END = CNT_W'(FK - 1);
   localparam logic [2:0]        MF_LAST  = 3'(ILAS_MF - 1);
   localparam logic [3:0]        FILT_MAX = 4'(SYNC_FILTER);

   typedef enum logic [1:0] {
      ST_CGS  = 2'd0,
      ST_ILAS = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t             state, state_nxt, out_state;
   logic               sync_ff1, sync_s;
   logic [3:0]         filt_cnt;
   logic [CNT_W-1:0]   lmfc_cnt;
   logic [2:0]         mf_cnt;
   logic               lmfc_last, resync, in_cfg;
   logic [3:0]         cfg_idx;
   logic [7:0]         cfg_sel, base_sum, n_octet;
   logic [LANES*8-1:0] octet_nxt;
   logic [LANES-1:0]   k_nxt;
   logic               ready_nxt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_ff1 <= 1'b0;
         sync_s   <= 1'b0;
      end else begin
         sync_ff1 <= sync_n;
         sync_s   <= sync_ff1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         filt_cnt <= '0;
      end else if (sync_s) begin
         filt_cnt <= '0;
      end else if (filt_cnt != FILT_MAX) begin
         filt_cnt <= filt_cnt + 4'd1;
      end
   end

   assign lmfc_last = (lmfc_cnt == LMFC_END);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lmfc_cnt <= '0;
      end else begin
         lmfc_cnt <= lmfc_last ? '0 : lmfc_cnt + CNT_W'(1);
      end
   end

   // Multiframe index is only meaningful in ILAS; it sits at 0 otherwise so ILAS always starts at MF0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mf_cnt <= '0;
      end else if (state != ST_ILAS) begin
         mf_cnt <= '0;
      end else if (lmfc_last) begin
         mf_cnt <= mf_cnt + 3'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_CGS;
      end else begin
         state <= state_nxt;
      end
   end

   // The state register leads the outputs by one cycle, except a resync which lands on the outputs at once.
   always_comb begin
      resync    = (state != ST_CGS) && (filt_cnt == FILT_MAX);
      state_nxt = state;
      case (state)
         ST_CGS: begin
            if (lmfc_last && sync_s) begin
               state_nxt = ST_ILAS;
            end
         end
         ST_ILAS: begin
            if (resync) begin
               state_nxt = ST_CGS;
            end else if (lmfc_last && (mf_cnt == MF_LAST)) begin
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (resync) begin
               state_nxt = ST_CGS;
            end
         end
         default: state_nxt = ST_CGS;
      endcase
      out_state = resync ? ST_CGS : state;
   end

   always_comb begin
      n_octet = 8'(lmfc_cnt);
      in_cfg  = (mf_cnt == 3'd1) && (lmfc_cnt >= CNT_W'(2)) && (lmfc_cnt <= CNT_W'(15));
      cfg_idx = lmfc_cnt[3:0] - 4'd2;
      cfg_sel = 8'h00;
      for (int jj = 0; jj < 14; jj++) begin
         if (cfg_idx == 4'(jj)) begin
            cfg_sel = cfg_data[jj*8 +: 8];
         end
      end
      // FCHK without the LID term; each lane adds its own index.
      base_sum = 8'h00;
      for (int jj = 0; jj < 13; jj++) begin
         if (jj != 2) begin
            base_sum = base_sum + cfg_data[jj*8 +: 8];
         end
      end
   end

   always_comb begin
      octet_nxt = {LANES{8'hBC}};
      k_nxt     = '1;
      ready_nxt = 1'b0;
      case (out_state)
         ST_ILAS: begin
            for (int i = 0; i < LANES; i++) begin
               k_nxt[i] = 1'b0;
               if (lmfc_cnt == '0) begin
                  octet_nxt[i*8 +: 8] = 8'h1C;
                  k_nxt[i]            = 1'b1;
               end else if (lmfc_last) begin
                  octet_nxt[i*8 +: 8] = 8'h7C;
                  k_nxt[i]            = 1'b1;
               end else if ((mf_cnt == 3'd1) && (lmfc_cnt == CNT_W'(1))) begin
                  octet_nxt[i*8 +: 8] = 8'h9C;
                  k_nxt[i]            = 1'b1;
               end else if (in_cfg) begin
                  if (cfg_idx == 4'd2) begin
                     octet_nxt[i*8 +: 8] = 8'(i);
                  end else if (cfg_idx == 4'd13) begin
                     octet_nxt[i*8 +: 8] = base_sum + 8'(i);
                  end else begin
                     octet_nxt[i*8 +: 8] = cfg_sel;
                  end
               end else begin
                  octet_nxt[i*8 +: 8] = n_octet;
               end
            end
         end
         ST_DATA: begin
            octet_nxt = tx_data;
            k_nxt     = '0;
            ready_nxt = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx_octet   <= {LANES{8'hBC}};
         tx_k       <= '1;
         tx_ready   <= 1'b0;
         lmfc_edge  <= 1'b0;
         link_state <= 2'd0;
      end else begin
         tx_octet   <= octet_nxt;
         tx_k       <= k_nxt;
         tx_ready   <= ready_nxt;
         lmfc_edge  <= (lmfc_cnt == '0);
         link_state <= out_state;
      end
   end

endmodule

// File: tb/tb_jesd204b_link_tx_ctrl.sv
// Directed bench for jesd204b_link_tx_ctrl with LANES=4, F=2, K=16, ILAS_MF=4, SYNC_FILTER=5.
module tb_jesd204b_link_tx_ctrl;

   logic          clock = 1'b0;
   logic          reset;
   logic          sync_n;
   logic [31:0]   tx_data;
   logic [111:0]  cfg_data;
   logic [31:0]   tx_octet;
   logic [3:0]    tx_k;
   logic          tx_ready;
   logic          lmfc_edge;
   logic [1:0]    link_state;

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   // ILAS spot checks: cycle after reset release, expected octets, K flags, link_state.
   int          ilas_cyc [15] = '{129, 130, 134, 160, 161, 162, 163, 164, 165, 166, 175, 176, 177, 224, 256};
   logic [31:0] ilas_oct [15] = '{32'h1C1C1C1C, 32'h01010101, 32'h05050505, 32'h7C7C7C7C, 32'h1C1C1C1C,
                                  32'h9C9C9C9C, 32'h01010101, 32'h02020202, 32'h03020100, 32'h04040404,
                                  32'h0D0D0D0D, 32'h5B5A5958, 32'h10101010, 32'h7C7C7C7C, 32'h7C7C7C7C};
   logic [3:0]  ilas_k   [15] = '{4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0,
                                  4'h0, 4'h0, 4'h0, 4'hF, 4'hF};

   jesd204b_link_tx_ctrl #(
      .LANES(4), .F(2), .K(16), .ILAS_MF(4), .SYNC_FILTER(5)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .sync_n     (sync_n),
      .tx_data    (tx_data),
      .cfg_data   (cfg_data),
      .tx_octet   (tx_octet),
      .tx_k       (tx_k),
      .tx_ready   (tx_ready),
      .lmfc_edge  (lmfc_edge),
      .link_state (link_state)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic advance_to(input int target);
      while (cyc < target) tick();
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      sync_n  = 1'b0;
      tx_data = 32'h11223344;
      #23;
      checks++;
      if ({tx_octet, tx_k, tx_ready, lmfc_edge, link_state} !== {32'hBCBCBCBC, 4'hF, 1'b0, 1'b0, 2'd0})
         $display("FAIL reset_values: got %h/%h/%b/%b/%0d required BCBCBCBC/F/0/0/0",
                  tx_octet, tx_k, tx_ready, lmfc_edge, link_state);
      else passed++;
      @(negedge clock);
      reset = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_cgs_hold();
      for (int i = 0; i < 100; i++) begin
         tick();
         checks++;
         if ({tx_octet, tx_k, tx_ready, lmfc_edge, link_state} !==
             {32'hBCBCBCBC, 4'hF, 1'b0, (cyc % 32 == 1), 2'd0})
            $display("FAIL cgs_hold cyc %0d: got %h/%h/%b/%b/%0d required BCBCBCBC/F/0/%0d/0",
                     cyc, tx_octet, tx_k, tx_ready, lmfc_edge, link_state, (cyc % 32 == 1));
         else passed++;
      end
   endtask

   task automatic test_ilas();
      advance_to(106);
      sync_n = 1'b1;
      while (cyc < 128) begin
         tick();
         checks++;
         if ({tx_octet, tx_k, link_state} !== {32'hBCBCBCBC, 4'hF, 2'd0})
            $display("FAIL cgs_until_boundary cyc %0d: got %h/%h/%0d required BCBCBCBC/F/0",
                     cyc, tx_octet, tx_k, link_state);
         else passed++;
      end
      for (int i = 0; i < 15; i++) begin
         advance_to(ilas_cyc[i]);
         checks++;
         if ({tx_octet, tx_k, tx_ready, lmfc_edge, link_state} !==
             {ilas_oct[i], ilas_k[i], 1'b0, (cyc % 32 == 1), 2'd1})
            $display("FAIL ilas_octet cyc %0d: got %h/%h/%b/%b/%0d required %h/%h/0/%0d/1",
                     cyc, tx_octet, tx_k, tx_ready, lmfc_edge, link_state,
                     ilas_oct[i], ilas_k[i], (cyc % 32 == 1));
         else passed++;
      end
      tick();
      checks++;
      if ({tx_octet, tx_k, tx_ready, lmfc_edge, link_state} !== {32'h11223344, 4'h0, 1'b1, 1'b1, 2'd2})
         $display("FAIL data_entry cyc %0d: got %h/%h/%b/%b/%0d required 11223344/0/1/1/2",
                  cyc, tx_octet, tx_k, tx_ready, lmfc_edge, link_state);
      else passed++;
   endtask

   task automatic test_data();
      tx_data = 32'hA5A55A5A;
      tick();
      checks++;
      if ({tx_octet, tx_k, tx_ready, link_state} !== {32'hA5A55A5A, 4'h0, 1'b1, 2'd2})
         $display("FAIL data_pass cyc %0d: got %h/%h/%b/%0d required A5A55A5A/0/1/2",
                  cyc, tx_octet, tx_k, tx_ready, link_state);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] vec [3] = '{32'h00000000, 32'hFFFFFFFF, 32'h0123CDEF};
      for (int i = 0; i < 3; i++) begin
         tx_data = vec[i];
         tick();
         checks++;
         if ({tx_octet, tx_k, tx_ready} !== {vec[i], 4'h0, 1'b1})
            $display("FAIL back_to_back %0d: got %h/%h/%b required %h/0/1",
                     i, tx_octet, tx_k, tx_ready, vec[i]);
         else passed++;
      end
   endtask

   task automatic test_sync_pulse();
      sync_n = 1'b0;
      repeat (4) tick();
      sync_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ({tx_octet, tx_k, tx_ready, link_state} !== {tx_data, 4'h0, 1'b1, 2'd2})
            $display("FAIL short_pulse_ignored cyc %0d: got %h/%h/%b/%0d required %h/0/1/2",
                     cyc, tx_octet, tx_k, tx_ready, link_state, tx_data);
         else passed++;
      end
   endtask

   task automatic test_resync();
      sync_n = 1'b0;
      repeat (5) tick();
      sync_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({tx_ready, link_state} !== {1'b1, 2'd2})
            $display("FAIL resync_not_early cyc %0d: got ready %b state %0d required 1/2",
                     cyc, tx_ready, link_state);
         else passed++;
      end
      tick();
      checks++;
      if ({tx_octet, tx_k, tx_ready, link_state} !== {32'hBCBCBCBC, 4'hF, 1'b0, 2'd0})
         $display("FAIL resync_cgs cyc %0d: got %h/%h/%b/%0d required BCBCBCBC/F/0/0",
                  cyc, tx_octet, tx_k, tx_ready, link_state);
      else passed++;
   endtask

   task automatic test_reset_mid_ilas();
      int start;
      start = (cyc / 32 + 1) * 32 + 1;
      advance_to(start - 1);
      checks++;
      if ({tx_octet, link_state} !== {32'hBCBCBCBC, 2'd0})
         $display("FAIL realign_wait cyc %0d: got %h/%0d required BCBCBCBC/0", cyc, tx_octet, link_state);
      else passed++;
      tick();
      checks++;
      if ({tx_octet, tx_k, lmfc_edge, link_state} !== {32'h1C1C1C1C, 4'hF, 1'b1, 2'd1})
         $display("FAIL realign_ilas cyc %0d: got %h/%h/%b/%0d required 1C1C1C1C/F/1/1",
                  cyc, tx_octet, tx_k, lmfc_edge, link_state);
      else passed++;
      advance_to(start + 64 + 5);
      checks++;
      if ({tx_octet, tx_k, link_state} !== {32'h05050505, 4'h0, 2'd1})
         $display("FAIL ilas_mf2 cyc %0d: got %h/%h/%0d required 05050505/0/1", cyc, tx_octet, tx_k, link_state);
      else passed++;
      reset = 1'b0;
      #1;
      checks++;
      if ({tx_octet, tx_k, tx_ready, lmfc_edge, link_state} !== {32'hBCBCBCBC, 4'hF, 1'b0, 1'b0, 2'd0})
         $display("FAIL async_reset: got %h/%h/%b/%b/%0d required BCBCBCBC/F/0/0/0",
                  tx_octet, tx_k, tx_ready, lmfc_edge, link_state);
      else passed++;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      cyc   = 0;
      tick();
      checks++;
      if ({tx_octet, lmfc_edge, link_state} !== {32'hBCBCBCBC, 1'b1, 2'd0})
         $display("FAIL lmfc_restart: got %h/%b/%0d required BCBCBCBC/1/0", tx_octet, lmfc_edge, link_state);
      else passed++;
      advance_to(32);
      checks++;
      if ({tx_octet, lmfc_edge, link_state} !== {32'hBCBCBCBC, 1'b0, 2'd0})
         $display("FAIL post_reset_cgs: got %h/%b/%0d required BCBCBCBC/0/0", tx_octet, lmfc_edge, link_state);
      else passed++;
      tick();
      checks++;
      if ({tx_octet, tx_k, lmfc_edge, link_state} !== {32'h1C1C1C1C, 4'hF, 1'b1, 2'd1})
         $display("FAIL post_reset_ilas: got %h/%h/%b/%0d required 1C1C1C1C/F/1/1",
                  tx_octet, tx_k, lmfc_edge, link_state);
      else passed++;
   endtask

   initial begin
      for (int j = 0; j < 14; j++) cfg_data[j*8 +: 8] = 8'(j + 1);
      test_reset();
      test_cgs_hold();
      test_ilas();
      test_data();
      test_back_to_back();
      test_sync_pulse();
      test_resync();
      test_reset_mid_ilas();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
